// File: rtl/adc_spi_capture.sv
// ADC front end: CNV/SCK timing generator with multi-lane SDO capture.
// Single-shot or continuous frames at a fixed frame period.
module adc_spi_capture #(
  parameter int DATA_BITS     = 16,
  parameter int NUM_LANES     = 1,
  parameter int CLK_DIV       = 1,
  parameter int CONV_CYCLES   = 4,
  parameter int SAMPLE_PERIOD = 48
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           continuous,
  input  logic [NUM_LANES-1:0]           sdo,
  output logic                           sck,
  output logic                           cnv,
  output logic                           busy,
  output logic [NUM_LANES*DATA_BITS-1:0] data,
  output logic                           data_valid
);

  localparam int MIN_PERIOD =
    CONV_CYCLES + 2 * CLK_DIV * DATA_BITS + 1;
  localparam int PERIOD =
    (SAMPLE_PERIOD < MIN_PERIOD) ? MIN_PERIOD : SAMPLE_PERIOD;
  localparam int PW = $clog2(PERIOD + 1);
  localparam int CW = $clog2(CONV_CYCLES + CLK_DIV + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int DW = NUM_LANES * DATA_BITS;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    ACQ,
    WAIT
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bits, bits_n;
  logic [DW-1:0] shreg, shreg_n;
  logic [DW-1:0] data_n;
  logic          sck_n, cnv_n, busy_n, dv_n;
  logic          last, pend, tick;

  // pcnt holds cycles since the CNV rise minus one
  assign last = (pcnt == PW'(PERIOD - 2));
  assign pend = (pcnt == PW'(PERIOD - 1));
  assign tick = (cnt == CW'(CLK_DIV - 1));

  always_comb begin
    state_n = state;
    pcnt_n  = pend ? pcnt : pcnt + PW'(1);
    cnt_n   = cnt;
    bits_n  = bits;
    shreg_n = shreg;
    data_n  = data;
    sck_n   = sck;
    cnv_n   = cnv;
    busy_n  = busy;
    dv_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start | continuous) begin
          cnv_n   = 1'b1;
          busy_n  = 1'b1;
          pcnt_n  = '0;
          cnt_n   = '0;
          state_n = CONV;
        end else begin
          busy_n = 1'b0;
        end
      end
      CONV: begin
        if (cnt == CW'(CONV_CYCLES - 1)) begin
          cnv_n   = 1'b0;
          cnt_n   = '0;
          bits_n  = '0;
          state_n = ACQ;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ACQ: begin
        if (!tick) begin
          cnt_n = cnt + CW'(1);
        end else begin
          cnt_n = '0;
          sck_n = !sck;
          if (!sck) begin
            for (int i = 0; i < NUM_LANES; i++) begin
              shreg_n[i*DATA_BITS +: DATA_BITS] =
                (shreg[i*DATA_BITS +: DATA_BITS] << 1)
                | DATA_BITS'(sdo[i]);
            end
          end else if (bits == BW'(DATA_BITS - 1)) begin
            data_n  = shreg;
            dv_n    = 1'b1;
            state_n = WAIT;
            // minimum period: the frame ends on the last SCK fall
            if (last && !continuous) begin
              busy_n  = 1'b0;
              state_n = IDLE;
            end
          end else begin
            bits_n = bits + BW'(1);
          end
        end
      end
      WAIT: begin
        if (pend) begin
          if (continuous) begin
            cnv_n   = 1'b1;
            pcnt_n  = '0;
            cnt_n   = '0;
            state_n = CONV;
          end else begin
            busy_n  = 1'b0;
            state_n = IDLE;
          end
        end else if (last && !continuous) begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pcnt       <= '0;
      cnt        <= '0;
      bits       <= '0;
      shreg      <= '0;
      data       <= '0;
      sck        <= 1'b0;
      cnv        <= 1'b0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_n;
      pcnt       <= pcnt_n;
      cnt        <= cnt_n;
      bits       <= bits_n;
      shreg      <= shreg_n;
      data       <= data_n;
      sck        <= sck_n;
      cnv        <= cnv_n;
      busy       <= busy_n;
      data_valid <= dv_n;
    end
  end

endmodule
